// File: rtl/decoder_stage_controller_pkg.sv
// Stage codes shared by the decoder stage controller and the processing units.
package decoder_stage_controller_pkg;

   localparam int STAGE_WIDTH = 3;

   typedef enum logic [STAGE_WIDTH-1:0] {
      STAGE_IDLE                = 3'd0,
      STAGE_MEASUREMENT_LOADING = 3'd1,
      STAGE_GROW                = 3'd2,
      STAGE_MERGE               = 3'd3,
      STAGE_PEELING             = 3'd4,
      STAGE_RESULT_VALID        = 3'd5,
      STAGE_WRITE_TO_MEM        = 3'd6,
      STAGE_RESET_ROOTS         = 3'd7
   } stage_e;

endpackage

// File: rtl/decoder_stage_controller_settle.sv
// merge_settle_detector: OR-reduces PE busy flags and counts consecutive idle MERGE cycles.
module merge_settle_detector #(
   parameter int unsigned PE_COUNT     = 64,
   parameter int unsigned MERGE_SETTLE = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_active,
   input  logic [PE_COUNT-1:0] i_busy,
   output logic                o_settled
);

   localparam int CNT_W = $clog2(MERGE_SETTLE) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MERGE_SETTLE - 1);

   logic             w_any_busy;
   logic [CNT_W-1:0] r_settle_cnt;

   assign w_any_busy = |i_busy;

   // Leaving MERGE zeroes the counter, so every MERGE entry starts from 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_settle_cnt <= '0;
      end else if (!i_active || w_any_busy) begin
         r_settle_cnt <= '0;
      end else if (r_settle_cnt != CNT_LAST) begin
         r_settle_cnt <= r_settle_cnt + 1'b1;
      end
   end

   assign o_settled = i_active && !w_any_busy && (r_settle_cnt == CNT_LAST);

endmodule

// File: rtl/decoder_stage_controller.sv
// Union-find decoder stage sequencer driving the shared global_stage bus.
// Optional growth cap enabled by defining MAX_GROWTH_EN.
module decoder_stage_controller
   import decoder_stage_controller_pkg::*;
#(
   parameter int unsigned PE_COUNT     = 64,
   parameter int unsigned MERGE_SETTLE = 3,
   parameter int unsigned GROW_CYCLES  = 2,
   parameter int unsigned ITER_WIDTH   = 8,
   parameter int unsigned MAX_GROWTH   = 200,
   parameter int unsigned NUM_CONTEXTS = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   output logic                   ready,
   output logic [STAGE_WIDTH-1:0] global_stage,
   input  logic [PE_COUNT-1:0]    busy,
   input  logic [PE_COUNT-1:0]    odd,
   output logic                   done,
   output logic [ITER_WIDTH-1:0]  iteration_count,
   output logic                   overflow,
   output logic [((NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1)-1:0] context_id
);

   localparam int CTX_W  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
   localparam int GROW_W = $clog2(GROW_CYCLES) + 1;
   localparam logic [GROW_W-1:0] GROW_LAST = GROW_W'(GROW_CYCLES - 1);
   localparam logic [CTX_W-1:0]  CTX_LAST  = CTX_W'(NUM_CONTEXTS - 1);

   stage_e              r_state;
   stage_e              w_state_d;
   logic [GROW_W-1:0]   r_grow_cnt;
   logic [ITER_WIDTH-1:0] r_iter;
   logic [CTX_W-1:0]    r_ctx;
   logic                w_settled;
   logic                w_any_odd;
   logic                w_at_cap;
   logic                w_accept;
   logic                w_grow_entry;

   merge_settle_detector #(
      .PE_COUNT     (PE_COUNT),
      .MERGE_SETTLE (MERGE_SETTLE)
   ) u_settle (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_active  (r_state == STAGE_MERGE),
      .i_busy    (busy),
      .o_settled (w_settled)
   );

   assign w_any_odd = |odd;

`ifdef MAX_GROWTH_EN
   assign w_at_cap = (r_iter == ITER_WIDTH'(MAX_GROWTH));
`else
   assign w_at_cap = 1'b0;
`endif

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         STAGE_IDLE:                if (start) w_state_d = STAGE_MEASUREMENT_LOADING;
         STAGE_MEASUREMENT_LOADING: w_state_d = STAGE_MERGE;
         STAGE_GROW:                if (r_grow_cnt == GROW_LAST) w_state_d = STAGE_MERGE;
         STAGE_MERGE: begin
            // odd is only trusted on the exit cycle, once the array has settled
            if (w_settled) begin
               w_state_d = (w_any_odd && !w_at_cap) ? STAGE_GROW : STAGE_PEELING;
            end
         end
         STAGE_PEELING:             w_state_d = STAGE_RESULT_VALID;
         STAGE_RESULT_VALID:
            w_state_d = (NUM_CONTEXTS > 1) ? STAGE_WRITE_TO_MEM : STAGE_RESET_ROOTS;
         STAGE_WRITE_TO_MEM:        w_state_d = STAGE_RESET_ROOTS;
         STAGE_RESET_ROOTS:         w_state_d = STAGE_IDLE;
         default:                   w_state_d = STAGE_IDLE;
      endcase
   end

   assign w_accept     = (r_state == STAGE_IDLE) && start;
   assign w_grow_entry = (w_state_d == STAGE_GROW) && (r_state != STAGE_GROW);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= STAGE_IDLE;
         r_grow_cnt <= '0;
         r_iter     <= '0;
         r_ctx      <= '0;
      end else begin
         r_state    <= w_state_d;
         r_grow_cnt <= (r_state == STAGE_GROW) ? r_grow_cnt + 1'b1 : '0;
         if (w_accept) begin
            r_iter <= '0;
         end else if (w_grow_entry && (r_iter != '1)) begin
            r_iter <= r_iter + 1'b1;
         end
         if (r_state == STAGE_WRITE_TO_MEM) begin
            r_ctx <= (r_ctx == CTX_LAST) ? '0 : r_ctx + 1'b1;
         end
      end
   end

`ifdef MAX_GROWTH_EN
   logic r_overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_overflow <= 1'b0;
      end else if ((r_state == STAGE_MERGE) && w_settled && w_any_odd && w_at_cap) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

   assign global_stage    = r_state;
   assign ready           = (r_state == STAGE_IDLE);
   assign done            = (r_state == STAGE_RESULT_VALID);
   assign iteration_count = r_iter;
   assign context_id      = r_ctx;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Scoreboard bench for decoder_stage_controller (default build, MAX_GROWTH_EN undefined).
module tb_decoder_stage_controller;
   import decoder_stage_controller_pkg::*;

   localparam int PE_COUNT     = 64;
   localparam int MERGE_SETTLE = 3;
   localparam int GROW_CYCLES  = 2;
   localparam int ITER_WIDTH   = 8;

   typedef struct {
      int iter;
      int lat;
      int ctx;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   start = 1'b0;
   logic                   ready;
   logic [STAGE_WIDTH-1:0] global_stage;
   logic [PE_COUNT-1:0]    busy = '0;
   logic [PE_COUNT-1:0]    odd = '0;
   logic                   done;
   logic [ITER_WIDTH-1:0]  iteration_count;
   logic                   overflow;
   logic [0:0]             context_id;

   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_ctx = 0;
   exp_t sb[$];

   decoder_stage_controller #(
      .PE_COUNT     (PE_COUNT),
      .MERGE_SETTLE (MERGE_SETTLE),
      .GROW_CYCLES  (GROW_CYCLES),
      .ITER_WIDTH   (ITER_WIDTH),
      .MAX_GROWTH   (4),
      .NUM_CONTEXTS (2)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .ready           (ready),
      .global_stage    (global_stage),
      .busy            (busy),
      .odd             (odd),
      .done            (done),
      .iteration_count (iteration_count),
      .overflow        (overflow),
      .context_id      (context_id)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One decode; expected result is queued on start and popped on done.
   task automatic run_decode(input int n_odd, input int busy_m, input int busy_len,
                             input int extra, input bit mid_start, input bit chk_trace);
      exp_t e;
      exp_t g;
      int   cyc = 1;
      int   grows = 0;
      int   gcyc = 0;
      int   merges = 0;
      int   mcyc = 0;
      int   n_done = 0;
      bit   finished = 0;
      logic [2:0] cur;
      logic [2:0] prev = STAGE_IDLE;
      int   trace[$];
      int   exp_tr[9] = '{1, 3, 3, 3, 4, 5, 6, 7, 0};

      @(negedge clk);
      odd      = '0;
      odd[5]   = (n_odd > 0);
      start    = 1'b1;
      exp_ctx  = (exp_ctx + 1) % 2;
      e.iter   = n_odd;
      e.lat    = 1 + MERGE_SETTLE + n_odd * (GROW_CYCLES + MERGE_SETTLE) + extra + 2;
      e.ctx    = exp_ctx;
      sb.push_back(e);
      @(negedge clk);
      while (cyc < 300) begin
         cur = global_stage;
         if (cur == STAGE_GROW && prev != STAGE_GROW) grows++;
         if (cur == STAGE_GROW) gcyc++;
         if (cur == STAGE_MERGE) begin
            if (prev != STAGE_MERGE) begin
               merges++;
               mcyc = 1;
            end else begin
               mcyc++;
            end
         end
         if (chk_trace) trace.push_back(int'(cur));
         odd    = '0;
         odd[5] = (grows < n_odd);
         busy   = '0;
         busy[17] = (cur == STAGE_MERGE) && (merges == 1) && (busy_len > 0) &&
                    (mcyc >= busy_m) && (mcyc < busy_m + busy_len);
         start  = mid_start && (cyc == 3);
         if (cyc == 3) check_eq("ready_mid_decode", ready, 0);
         if (done) begin
            n_done++;
            if (sb.size() == 0) begin
               check_eq("scoreboard_empty", 1, 0);
            end else begin
               g = sb.pop_front();
               check_eq("done_latency", cyc, g.lat);
               check_eq("iteration_count", iteration_count, g.iter);
               check_eq("overflow", overflow, 0);
            end
         end
         if (cur == STAGE_IDLE) begin
            check_eq("context_id", context_id, e.ctx);
            check_eq("ready_after", ready, 1);
            finished = 1;
            break;
         end
         prev = cur;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      busy  = '0;
      odd   = '0;
      check_eq("decode_finished", finished, 1);
      check_eq("done_pulses", n_done, 1);
      check_eq("grow_cycles", gcyc, n_odd * GROW_CYCLES);
      if (chk_trace) begin
         check_eq("trace_len", trace.size(), 9);
         for (int i = 0; i < 9 && i < trace.size(); i++) check_eq("stage_trace", trace[i], exp_tr[i]);
      end
   endtask

   // Reset asserted mid-cycle during the third GROW phase.
   task automatic run_reset_in_grow();
      int   cyc = 0;
      int   grows = 0;
      logic [2:0] prev = STAGE_IDLE;
      @(negedge clk);
      odd    = '0;
      odd[5] = 1'b1;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 200 && grows < 3) begin
         if (global_stage == STAGE_GROW && prev != STAGE_GROW) grows++;
         prev = global_stage;
         if (grows < 3) begin
            @(negedge clk);
            cyc++;
         end
      end
      check_eq("reached_grow3", grows, 3);
      check_eq("iter_before_reset", iteration_count, 3);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rst_stage", global_stage, STAGE_IDLE);
      check_eq("rst_iter", iteration_count, 0);
      check_eq("rst_ready", ready, 1);
      check_eq("rst_ctx", context_id, 0);
      check_eq("rst_done", done, 0);
      odd = '0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_ctx = 0;
   endtask

   initial begin
      #1;
      check_eq("reset_stage", global_stage, STAGE_IDLE);
      check_eq("reset_ready", ready, 1);
      check_eq("reset_done", done, 0);
      check_eq("reset_iter", iteration_count, 0);
      check_eq("reset_overflow", overflow, 0);
      check_eq("reset_ctx", context_id, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      run_decode(0, 0, 0, 0, 1'b0, 1'b1);   // no odd cluster
      run_decode(2, 0, 0, 0, 1'b0, 1'b0);   // two grow iterations
      run_decode(0, 2, 4, 5, 1'b0, 1'b0);   // late busy extends MERGE
      run_decode(5, 0, 0, 0, 1'b0, 1'b0);   // uncapped growth past 4
      run_reset_in_grow();
      for (int k = 0; k < 3; k++) run_decode(0, 0, 0, 0, 1'b1, 1'b0);
      check_eq("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decoder_stage_controller.md
# decoder_stage_controller

Central sequencer that drives the shared `global_stage` bus into every processing unit of the single-FPGA union-find decoder. It watches the units' aggregated `busy` and `odd` flags and steps the array through load, grow/merge iterations, peeling, result and context writeback. It is the initiator side of the stage/busy protocol that each processing unit answers. One instance sits at the top of the decoder, beside the PE array.

## Interface
Parameters:
- `PE_COUNT`, 64: number of processing units; sets the width of `busy` and `odd`.
- `MERGE_SETTLE`, 3: consecutive all-idle cycles required before a merge is complete.
- `GROW_CYCLES`, 2: cycles `STAGE_GROW` is held per iteration.
- `ITER_WIDTH`, 8: width of the iteration counter.
- `MAX_GROWTH`, 200: iteration cap; used only with `MAX_GROWTH_EN`.
- `NUM_CONTEXTS`, 2: number of decoding contexts held in PE memory.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to decode the measurements currently presented to the PEs.
- `ready`  out  1  controller is idle and can accept `start`.
- `global_stage`  out  `STAGE_WIDTH`  registered stage broadcast to all PEs.
- `busy`  in  `PE_COUNT`  per-PE busy, registered inside each PE.
- `odd`  in  `PE_COUNT`  per-PE odd-cluster flag.
- `done`  out  1  one-cycle pulse when the result is valid.
- `iteration_count`  out  `ITER_WIDTH`  number of grow iterations performed for the current decode.
- `overflow`  out  1  the decode was aborted at `MAX_GROWTH`.
- `context_id`  out  `$clog2(NUM_CONTEXTS)`  context currently active in the PEs.

## Operation
- `global_stage` is driven directly by the FSM state register. FSM states map one-to-one onto stage codes.
- IDLE (`STAGE_IDLE`):
  - `ready`=1.
  - When `start` is high, clear `iteration_count` and `overflow`, then go to LOAD.
- LOAD (`STAGE_MEASUREMENT_LOADING`): lasts 1 cycle, then MERGE. The initial merge settles roots and parity before the first grow.
- GROW (`STAGE_GROW`):
  - Held for `GROW_CYCLES` cycles, then MERGE.
  - `iteration_count` increments (saturating) on entry.
- MERGE (`STAGE_MERGE`):
  - `settle_cnt` is cleared on entry.
  - `settle_cnt` increments when `|busy`==0 and is cleared when `|busy`==1.
  - Exit when `settle_cnt`==`MERGE_SETTLE`-1 and `|busy`==0:
    - if `|odd`, go to GROW;
    - otherwise go to PEEL.
- PEEL (`STAGE_PEELING`): 1 cycle, then RESULT.
- RESULT (`STAGE_RESULT_VALID`): 1 cycle; `done`=1 during this cycle. Then:
  - WRMEM if `NUM_CONTEXTS`>1;
  - otherwise RSTROOT.
- WRMEM (`STAGE_WRITE_TO_MEM`):
  - 1 cycle, then RSTROOT.
  - `context_id` increments, wrapping `NUM_CONTEXTS`-1 → 0.
- RSTROOT (`STAGE_RESET_ROOTS`): 1 cycle, then IDLE.
- `start` is ignored outside IDLE and is not queued.
- `odd` is sampled only on the MERGE exit cycle, when it is guaranteed stable.

## Timing
- Reset values:
  - `global_stage`=`STAGE_IDLE`, `ready`=1, `done`=0.
  - `iteration_count`=0, `overflow`=0, `context_id`=0, `settle_cnt`=0.
- Asynchronous assertion of reset aborts any stage immediately. The PEs see `STAGE_IDLE` on the next edge they sample.
- `start` accepted at edge N: `global_stage`=LOAD during cycle N+1 and MERGE from N+2.
- Busy round-trip latency is 2 cycles (PE stage register, then busy register). The `MERGE_SETTLE`=3 default covers it plus one cycle of margin.
- Minimum decode with no odd cluster, from accept to `done`: 1 LOAD + 3 MERGE + 1 PEEL, so `done` is high in cycle N+6.
- Each grow iteration adds `GROW_CYCLES` + at least `MERGE_SETTLE` cycles.
- `iteration_count` saturates at 2^`ITER_WIDTH`-1.

## Configuration
- `MAX_GROWTH_EN` defined:
  - At the MERGE exit, if `|odd` and `iteration_count`==`MAX_GROWTH`, go to PEEL instead of GROW.
  - `overflow` is set and holds until the next accepted `start`.
- `MAX_GROWTH_EN` undefined:
  - Growth is unbounded.
  - `overflow` is tied to 0 and `MAX_GROWTH` is unused.

## Structure
- The shared `parameters.sv` package holds `STAGE_WIDTH`=3 and the stage codes: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, PEELING=4, RESULT_VALID=5, WRITE_TO_MEM=6, RESET_ROOTS=7.
- The PE and this controller must share that one definition.
- Sub-module `merge_settle_detector`: OR-reduces `busy` (optionally through a pipelined reduction tree) and owns `settle_cnt`. It outputs a `settled` pulse.

## Test plan
- No errors: `start` with all `busy`=0 and `odd`=0 → stage sequence LOAD, MERGE×3, PEEL, RESULT, WRMEM, RSTROOT, IDLE; `done` at cycle 6; `iteration_count`=0; `context_id`=1.
- Two iterations: `odd[5]`=1 for the first two merge exits, then 0 → two GROW phases of 2 cycles each; `iteration_count`=2; `done` asserted.
- Late busy: `busy[17]` asserted for 4 cycles starting at MERGE cycle 2 → MERGE is extended until 3 consecutive idle cycles follow the deassertion.
- Cap: with `MAX_GROWTH_EN` defined and `MAX_GROWTH`=4, `odd` held at 1 → exactly 4 GROW phases, then PEEL; `overflow`=1. Without the macro, GROW continues past 4.
- Reset during GROW at iteration 3: `reset_n` low → `global_stage`=IDLE, `iteration_count`=0 and `ready`=1 without waiting for a clock edge.
- Context wrap with `NUM_CONTEXTS`=2: three back-to-back decodes → `context_id` sequence 1, 0, 1; `start` pulsed mid-decode is ignored.
